// File: rtl/fetch_controller.sv
// Fetch sequencer: drives the external program_counter's next value and runs the
// request/grant/response handshake to instruction memory, handing instructions to decode.
module fetch_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        flush;
  logic [31:0] target_aligned;

  assign flush          = trap | redirect_valid;
  assign target_aligned = {redirect_target[31:2], 2'b00};
  assign imem_addr      = pc_cur;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      instr_q    <= NOP;
      instr_pc_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // pc_next priority: trap, then redirect, then advance on accepted instruction, else hold.
  always_comb begin
    pc_next = pc_cur;
    if (!rst || state_q == IDLE) begin
      pc_next = RESET_VECTOR;
    end else if (trap) begin
      pc_next = TRAP_VECTOR;
    end else if (redirect_valid) begin
      pc_next = target_aligned;
    end else if (state_q == VALID && !stall) begin
      pc_next = pc_cur + 32'd4;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) state_d = flush ? DRAIN : WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (flush) begin
            state_d = REQ;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_cur;
            state_d    = VALID;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      VALID: begin
        instr_valid = 1'b1;
        if (flush || !stall) state_d = REQ;
      end
      DRAIN: begin
        // A granted response is still in flight; swallow it before re-requesting.
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with an external PC register model and an
// instruction scoreboard checked by an independent monitor.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t sb_q[$];

  fetch_controller #(
    .RESET_VECTOR(32'h0000_0000),
    .TRAP_VECTOR (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_cur         (pc_cur),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .trap           (trap)
  );

  always #5 clk = ~clk;

  // program_counter register: loads pc_next unconditionally every clock.
  always @(posedge clk) pc_cur <= pc_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: compare each newly presented instruction against the scoreboard.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst === 1'b1 && instr_valid === 1'b1 && !prev_valid) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL mon_unexpected: instr %08h pc %08h shown with nothing expected", instr, instr_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (instr !== e.instr || instr_pc !== e.pc) begin
          bad++;
          $display("FAIL mon_instr: got %08h@%08h expected %08h@%08h", instr, instr_pc, e.instr, e.pc);
        end else begin
          $display("ok   mon_instr: %08h@%08h", instr, instr_pc);
        end
      end
    end
    prev_valid = (rst === 1'b1) && (instr_valid === 1'b1);
  end

  // REQ cycle with grant, then WAIT cycle with response; returns at the VALID drive point.
  task automatic fetch_to_valid(input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    imem_gnt = 1'b1;
    smp();
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, addr);
    e.instr = data;
    e.pc    = addr;
    sb_q.push_back(e);
    cyc();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    smp();
    chk("wait_req", {31'd0, imem_req}, 32'd0);
    cyc();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0; trap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    smp();
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'h0);
    cyc();

    // 1: first fetch from the reset vector
    rst = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h0000_0040; // ignored in IDLE
    smp();
    chk("idle_pc_next", pc_next, 32'h0);
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    fetch_to_valid(32'h0, 32'h0050_0093);

    // 2: stall holds the instruction and the PC
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("stall_pc_next", pc_next, 32'h0);
      chk("stall_instr", instr, 32'h0050_0093);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      cyc();
    end
    stall = 1'b0;
    smp();
    chk("adv_pc_next", pc_next, 32'h4);
    cyc();

    // 3: redirect in WAIT, late response must be discarded
    imem_gnt = 1'b1;
    smp();
    chk("req4_addr", imem_addr, 32'h4);
    cyc();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_0203;
    smp();
    chk("redir_pc_next", pc_next, 32'h0000_0200);
    cyc();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
      smp();
      chk("drain_req", {31'd0, imem_req}, 32'd0);
      cyc();
    end
    imem_rvalid = 1'b0;

    // 4: trap beats redirect
    trap = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0040;
    smp();
    chk("req200_addr", imem_addr, 32'h0000_0200);
    chk("trap_pc_next", pc_next, 32'h0000_0100);
    cyc();
    trap = 1'b0; redirect_valid = 1'b0;
    fetch_to_valid(32'h0000_0100, 32'h1111_1111);
    smp();
    chk("adv104_pc_next", pc_next, 32'h0000_0104);
    cyc();

    // 5: wrap at top of address space (target low bits masked)
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    smp();
    chk("req104_addr", imem_addr, 32'h0000_0104);
    chk("mask_pc_next", pc_next, 32'hFFFF_FFFC);
    cyc();
    redirect_valid = 1'b0;
    fetch_to_valid(32'hFFFF_FFFC, 32'h2222_2222);
    smp();
    chk("wrap_pc_next", pc_next, 32'h0);
    cyc();

    // spurious rvalid in REQ is ignored
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    smp();
    chk("spur_addr", imem_addr, 32'h0);
    cyc();
    imem_rvalid = 1'b0;
    smp();
    chk("spur_req", {31'd0, imem_req}, 32'd1);
    chk("spur_valid", {31'd0, instr_valid}, 32'd0);
    cyc();

    // redirect overrides stall in VALID
    fetch_to_valid(32'h0, 32'h3333_3333);
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0080;
    smp();
    chk("stall_redir_pc_next", pc_next, 32'h0000_0080);
    cyc();
    stall = 1'b0; redirect_valid = 1'b0;

    // 6: reset during WAIT, stale response afterwards
    imem_gnt = 1'b1;
    smp();
    chk("req80_addr", imem_addr, 32'h0000_0080);
    cyc();
    imem_gnt = 1'b0;
    rst = 1'b0;
    smp();
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_pc_next", pc_next, 32'h0);
    chk("mid_rst_instr", instr, 32'h0000_0013);
    chk("mid_rst_instr_pc", instr_pc, 32'h0);
    cyc();
    cyc();
    rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    smp();
    chk("post_rst_req", {31'd0, imem_req}, 32'd0);
    chk("post_rst_pc_next", pc_next, 32'h0);
    cyc();
    smp();
    chk("post_rst_req1", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    cyc();
    imem_rvalid = 1'b0;
    smp();
    chk("post_rst_valid2", {31'd0, instr_valid}, 32'd0);
    chk("post_rst_instr", instr, 32'h0000_0013);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences the program_counter register and the instruction-memory fetch port.
- Every cycle it computes the value loaded into program_counter (which loads unconditionally each clock): hold on stall, PC+4 on advance, target on redirect or trap.
- It runs a request/grant/response handshake to instruction memory and presents fetched instructions to decode with a valid/stall handshake.
- It sits between program_counter, instruction memory and the decode stage.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
TRAP_VECTOR, 32'h0000_0100, fetch address on trap.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
pc_cur  input  32  current value of program_counter.
pc_next  output  32  next value for program_counter.
imem_req  output  1  fetch request.
imem_addr  output  32  fetch address.
imem_gnt  input  1  memory accepted the request this cycle.
imem_rvalid  input  1  read data valid.
imem_rdata  input  32  read data.
instr_valid  output  1  instr/instr_pc hold a valid instruction.
instr  output  32  fetched instruction.
instr_pc  output  32  address of instr.
stall  input  1  decode cannot accept instr this cycle.
redirect_valid  input  1  branch/jump taken.
redirect_target  input  32  branch/jump target.
trap  input  1  exception; highest priority.

Behaviour:
- **Address outputs:** imem_addr = pc_cur (combinational). Redirect targets have bits [1:0] forced to 0 before use.
- **States:** IDLE, REQ, WAIT, VALID, DRAIN.
- **Reset** (rst low, asynchronous):
  - state = IDLE, imem_req = 0, instr_valid = 0, instr = 32'h0000_0013, instr_pc = 0.
  - pc_next = RESET_VECTOR while rst is low and while in IDLE.
- **pc_next rule, in priority order:**
  - trap → TRAP_VECTOR.
  - redirect_valid → target.
  - VALID && !stall → pc_cur + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
  - otherwise → pc_cur.
- **IDLE:** next state is REQ unconditionally. Trap/redirect in IDLE are ignored; pc_next stays RESET_VECTOR.
- **REQ:** imem_req = 1.
  - Address stays stable until imem_gnt unless a redirect/trap occurs.
  - gnt && no redirect → WAIT.
  - gnt && redirect/trap → DRAIN (granted response must be discarded).
  - no gnt && redirect/trap → REQ; the new address is presented next cycle.
- **WAIT:** imem_req = 0.
  - rvalid && no redirect → instr <= imem_rdata, instr_pc <= pc_cur, instr_valid <= 1; go to VALID.
  - rvalid && redirect/trap → data discarded; go to REQ.
  - !rvalid && redirect/trap → DRAIN.
- **VALID:** instr_valid = 1; instr and instr_pc are stable while stall = 1.
  - !stall → instr_valid <= 0; go to REQ.
  - redirect/trap (any stall value) → instr_valid <= 0; go to REQ.
- **DRAIN:** imem_req = 0; wait for imem_rvalid and discard it, then go to REQ.
  - A further redirect in DRAIN updates pc_next; state remains DRAIN.
- **Spurious rvalid:** imem_rvalid in IDLE, REQ or VALID is ignored.
- **Latency:** with gnt in the request cycle and rvalid the next cycle, instr_valid rises 2 cycles after imem_req rises. Back-to-back fetch throughput is one instruction per 3 cycles minimum.
- **Redirect and trap together:** trap wins.
- **Redirect while stalled:** overrides the stall.
- **Reset mid-operation:** an outstanding memory response arriving after reset release is ignored, because the FSM is in IDLE/REQ.

Test Plan:
1. Reset with RESET_VECTOR = 0, release, gnt and rvalid immediate, rdata = 32'h00500093 → imem_addr = 0, instr_valid high with instr = 32'h00500093, instr_pc = 0; next fetch address 4.
2. stall held high 5 cycles in VALID → pc_next == pc_cur, instr/instr_pc unchanged; one cycle after stall falls, pc_cur = instr_pc + 4.
3. redirect_valid with target 32'h0000_0203 during WAIT, rvalid 3 cycles later → that data is never shown on instr_valid; next imem_addr = 32'h0000_0200.
4. trap and redirect_valid (target 32'h40) in the same cycle → next pc = 32'h0000_0100.
5. Fetch at pc 32'hFFFF_FFFC, advance with no stall → pc_next = 32'h0000_0000.
6. Assert rst low during WAIT, release, then send a stale rvalid → outputs at reset values, stale data ignored, first request addresses RESET_VECTOR.
